// File: rtl/bsg_fsb_node_out_arbiter.sv
// bsg_fsb_node_out_arbiter: round-robin arbiter of FSB nodes onto one registered outbound port.
// Define BSG_FSB_ARB_STALL_CNT_EN to enable the saturating back-pressure counter on stall_cnt_o.
module bsg_fsb_node_out_arbiter #(
  parameter int nodes_p = 4,
  parameter int width_p = 80,
  parameter int id_width_lp = (nodes_p > 1) ? $clog2(nodes_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [nodes_p-1:0]         node_v_i,
  input  logic [nodes_p*width_p-1:0] node_data_i,
  output logic [nodes_p-1:0]         node_yumi_o,
  input  logic [nodes_p-1:0]         node_en_i,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       ready_i,
  output logic [id_width_lp-1:0]     grant_id_o,
  output logic [15:0]                stall_cnt_o
);
  logic [id_width_lp-1:0] last_grant, gnt_id, idx;
  logic [nodes_p-1:0] elig;
  logic [width_p-1:0] sel_data;
  logic free, found, take;
  assign elig = node_v_i & node_en_i;
  assign free = ~v_o | ready_i;
  assign take = free & found & ~reset_i;
  // search starts just after the last winner and wraps
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int i = 1; i <= nodes_p; i++) begin
      idx = id_width_lp'((int'(last_grant) + i) % nodes_p);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < nodes_p; i++)
      if (gnt_id == id_width_lp'(i)) sel_data = node_data_i[i*width_p +: width_p];
  end
  assign node_yumi_o = take ? nodes_p'(1) << gnt_id : '0;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      v_o <= 1'b0;
      grant_id_o <= '0;
      last_grant <= id_width_lp'(nodes_p - 1);
    end else if (free) begin
      v_o <= found;
      if (found) begin
        grant_id_o <= gnt_id;
        last_grant <= gnt_id;
      end
    end
  always_ff @(posedge clk_i)
    if (take) data_o <= sel_data;
`ifdef BSG_FSB_ARB_STALL_CNT_EN
  logic [15:0] stall_r;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) stall_r <= '0;
    else if (v_o && !ready_i && stall_r != 16'hFFFF) stall_r <= stall_r + 16'd1;
  assign stall_cnt_o = stall_r;
`else
  assign stall_cnt_o = 16'h0000;
`endif
endmodule

// File: tb/tb_bsg_fsb_node_out_arbiter.sv
// tb_bsg_fsb_node_out_arbiter: directed and random stimulus against a queue-free behavioural model.
module tb_bsg_fsb_node_out_arbiter;
  localparam int N = 4, W = 16;
  logic clk_i = 1'b0, reset_i = 1'b1, ready_i = 1'b0, v_o;
  logic [N-1:0] node_v_i = '0, node_en_i = '0, node_yumi_o, obs_yumi;
  logic [N*W-1:0] node_data_i = '0;
  logic [W-1:0] data_o, mdata;
  logic [1:0] grant_id_o;
  logic [15:0] stall_cnt_o;
  int errors = 0, checks = 0, mid, mlast, mstall;
  bit mv;
  bsg_fsb_node_out_arbiter #(.nodes_p(N), .width_p(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .node_v_i(node_v_i), .node_data_i(node_data_i),
    .node_yumi_o(node_yumi_o), .node_en_i(node_en_i), .v_o(v_o), .data_o(data_o),
    .ready_i(ready_i), .grant_id_o(grant_id_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    mv = 0;
    mlast = N - 1;
    mstall = 0;
    mid = 0;
  endtask
  // one cycle: randomize data, compare against the model, advance the model across the edge
  task automatic step();
    node_data_i = {$urandom, $urandom};
    #1;
    begin
      bit fr;
      int gid, e, ey;
      fr = !mv || ready_i;
      e = int'(node_v_i & node_en_i);
      gid = -1;
      for (int k = 1; k <= N; k++)
        if (gid < 0 && ((e >> ((mlast + k) % N)) & 1) == 1) gid = (mlast + k) % N;
      ey = (fr && gid >= 0) ? (1 << gid) : 0;
      obs_yumi = node_yumi_o;
      chk("v_o", longint'(v_o), longint'(mv));
      if (mv) begin
        chk("data_o", longint'(data_o), longint'(mdata));
        chk("grant_id_o", longint'(grant_id_o), longint'(mid));
      end
      chk("node_yumi_o", longint'(node_yumi_o), longint'(ey));
      chk("stall_cnt_o", longint'(stall_cnt_o), longint'(mstall));
`ifdef BSG_FSB_ARB_STALL_CNT_EN
      if (mv && !ready_i && mstall < 65535) mstall++;
`endif
      if (fr) begin
        mv = gid >= 0;
        if (gid >= 0) begin
          mdata = W'(node_data_i >> (gid * W));
          mid = gid;
          mlast = gid;
        end
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask
  initial begin
    model_reset();
    node_v_i = 4'b1111;
    node_en_i = 4'b1111;
    @(negedge clk_i);
    #1;
    chk("rst_v", longint'(v_o), 0);
    chk("rst_yumi", longint'(node_yumi_o), 0);
    chk("rst_gid", longint'(grant_id_o), 0);
    chk("rst_stall", longint'(stall_cnt_o), 0);
    reset_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_all_yumi", longint'(obs_yumi), longint'(1 << (i % 4)));
      chk("rr_all_v", longint'(v_o), 1);
      chk("rr_all_gid", longint'(grant_id_o), longint'(i % 4));
    end
    node_v_i = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_yumi", longint'(obs_yumi), (i % 2) ? 8 : 2);
      chk("alt_gid", longint'(grant_id_o), (i % 2) ? 3 : 1);
    end
    node_v_i = 4'b0100;
    step();
    chk("n2_yumi", longint'(obs_yumi), 4);
    node_v_i = 4'b1000;
    ready_i = 1'b0;
    repeat (5) begin
      step();
      chk("stall_yumi", longint'(obs_yumi), 0);
    end
    chk("stall_gid", longint'(grant_id_o), 2);
`ifdef BSG_FSB_ARB_STALL_CNT_EN
    chk("stall_cnt5", longint'(stall_cnt_o), 5);
`else
    chk("stall_cnt0", longint'(stall_cnt_o), 0);
`endif
    ready_i = 1'b1;
    step();
    chk("drain_yumi", longint'(obs_yumi), 8);
    chk("drain_gid", longint'(grant_id_o), 3);
    node_v_i = 4'b0010;
    step();
    chk("n1_yumi", longint'(obs_yumi), 2);
    node_en_i = 4'b1101;
    node_v_i = 4'b1010;
    ready_i = 1'b0;
    repeat (3) step();
    chk("dis_gid", longint'(grant_id_o), 1);
    node_v_i = 4'b0010;
    ready_i = 1'b1;
    repeat (3) begin
      step();
      chk("dis_yumi", longint'(obs_yumi), 0);
    end
    chk("dis_v", longint'(v_o), 0);
    node_en_i = 4'b1111;
    node_v_i = 4'b1111;
    step();
    ready_i = 1'b0;
    step();
    chk("pre_rst_v", longint'(v_o), 1);
    reset_i = 1'b1;
    #1;
    chk("arst_v", longint'(v_o), 0);
    chk("arst_stall", longint'(stall_cnt_o), 0);
    chk("arst_yumi", longint'(node_yumi_o), 0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    ready_i = 1'b1;
    step();
    chk("post_rst_yumi", longint'(obs_yumi), 1);
    repeat (2000) begin
      node_v_i = N'($urandom);
      node_en_i = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
      ready_i = $urandom_range(0, 3) != 0;
      step();
    end
`ifdef BSG_FSB_ARB_STALL_CNT_EN
    node_v_i = 4'b0001;
    node_en_i = 4'b1111;
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    repeat (70000) @(negedge clk_i);
    #1;
    chk("sat_stall", longint'(stall_cnt_o), 65535);
    mstall = 65535;
    step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
